// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned UART_DATA_W   = 8;
    localparam int unsigned UART_BAUD_W   = 20;
    localparam int unsigned UART_BAUD_MIN = 4;

    // Receive FSM states
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line synchroniser: two metastability flops, a delayed copy and a
// registered falling-edge flag. Reset leaves the line looking idle (high).
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s,
    output logic fall
);

    logic sync1;
    logic rx_p;

    // Synchronise the pin and register a one-cycle pulse on each high-to-low transition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_p  <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
            rx_p  <= rx_s;
            fall  <= rx_p & ~rx_s;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-bit aligned mid-bit sampling of 8N1 frames,
// LSB-first assembly, and a one-entry valid/ready output buffer.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_W   = UART_BAUD_W,
    parameter int unsigned BAUD_MIN = UART_BAUD_MIN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [BAUD_W-1:0]      baud,
    input  logic                   rx_in,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   busy,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int unsigned IDX_W = $clog2(UART_DATA_W);

    localparam logic [BAUD_W-1:0] BAUD_ONE   = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_FLOOR = BAUD_W'(BAUD_MIN);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(UART_DATA_W - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);

    logic                   rx_s;
    logic                   fall;
    rx_state_t              state;
    logic [BAUD_W-1:0]      cnt;
    logic [BAUD_W-1:0]      bit_len;
    logic [BAUD_W-1:0]      half_len;
    logic [BAUD_W-1:0]      baud_eff;
    logic [IDX_W-1:0]       bit_idx;
    logic [UART_DATA_W-1:0] shreg;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rx_in (rx_in),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    // Divisors below the floor would leave no room for a mid-bit sample
    always_comb begin
        baud_eff = (baud < BAUD_FLOOR) ? BAUD_FLOOR : baud;
    end

    assign busy = (state != IDLE);

    // Frame sequencing, sampling, and the output buffer with its status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_len   <= BAUD_FLOOR;
            half_len  <= BAUD_FLOOR >> 1;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Consumer drain; a load below in the same cycle overrides this
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (!en) begin
                // Abandon any partial frame; the buffer keeps draining
                state <= IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (fall) begin
                            state    <= START;
                            cnt      <= '0;
                            bit_len  <= baud_eff;
                            half_len <= baud_eff >> 1;
                        end
                    end
                    START: begin
                        if (cnt == half_len - BAUD_ONE) begin
                            if (rx_s) begin
                                state <= IDLE;
                            end else begin
                                state   <= DATA;
                                cnt     <= '0;
                                bit_idx <= '0;
                            end
                        end else begin
                            cnt <= cnt + BAUD_ONE;
                        end
                    end
                    DATA: begin
                        if (cnt == bit_len - BAUD_ONE) begin
                            shreg   <= {rx_s, shreg[UART_DATA_W-1:1]};
                            cnt     <= '0;
                            bit_idx <= bit_idx + IDX_ONE;
                            if (bit_idx == IDX_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            cnt <= cnt + BAUD_ONE;
                        end
                    end
                    STOP: begin
                        if (cnt == bit_len - BAUD_ONE) begin
                            state <= IDLE;
                            cnt   <= '0;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                            end else if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + BAUD_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus random frames,
// with expectations derived from the frame timing rules.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [19:0] baud = 20'd16;
    logic        rx_in = 1'b1;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    int t = 0;
    bit line_q[$];
    logic seen_a;
    logic seen_b;

    uart_rx_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .baud      (baud),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Pin driver: one queued line level per clock, idle high when empty
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (line_q.size() > 0) rx_in = line_q.pop_front();
            else rx_in = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_b(input int b);
        return (b < 4) ? 4 : b;
    endfunction

    // Cycle of the stop-bit sample, relative to the pin falling edge at cycle 0
    function automatic int land(input int b);
        return 3 + eff_b(b) / 2 + 9 * eff_b(b);
    endfunction

    // Queue a whole 8N1 frame: start, data LSB-first, stop, each eff_b(b) cycles
    task automatic push_frame(input logic [7:0] data, input int b, input bit stop);
        int bl = eff_b(b);
        for (int i = 0; i < bl; i++) line_q.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < bl; i++) line_q.push_back(data[k]);
        for (int i = 0; i < bl; i++) line_q.push_back(stop);
    endtask

    task automatic settle();
        while (line_q.size() > 0) tick();
        repeat (8) tick();
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("drain_valid", rx_valid, 1'b0);
    endtask

    initial begin
        logic [7:0] rd;
        int rb;
        bit rs;
        int l;

        // Reset state
        repeat (3) tick();
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        rst = 1'b1;
        en = 1'b1;
        repeat (4) tick();

        // Single frame, baud 16
        baud = 20'd16;
        push_frame(8'hA5, 16, 1'b1);
        t = -1;
        run_to(3);   chk("t1_busy_d", busy, 1'b0);
        run_to(4);   chk("t1_busy_d1", busy, 1'b1);
        run_to(155); chk("t1_busy_stop", busy, 1'b1);
        chk("t1_valid_early", rx_valid, 1'b0);
        run_to(156); chk("t1_valid", rx_valid, 1'b1);
        chk("t1_data", rx_data, 8'hA5);
        chk("t1_busy_end", busy, 1'b0);
        run_to(160); chk("t1_hold", rx_valid, 1'b1);
        rx_ready = 1'b1;
        run_to(161); rx_ready = 1'b0;
        chk("t1_drained", rx_valid, 1'b0);
        settle();

        // Glitch rejection
        repeat (3) line_q.push_back(1'b0);
        t = -1;
        run_to(11); chk("gl_busy_h", busy, 1'b1);
        run_to(12); chk("gl_busy_idle", busy, 1'b0);
        seen_a = 1'b0;
        seen_b = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            seen_a |= rx_valid;
            seen_b |= frame_err;
        end
        chk("gl_no_valid", seen_a, 1'b0);
        chk("gl_no_ferr", seen_b, 1'b0);

        // Framing error, then a good frame
        baud = 20'd8;
        push_frame(8'h3C, 8, 1'b0);
        t = -1;
        run_to(79); chk("fe_pre", frame_err, 1'b0);
        run_to(80); chk("fe_pulse", frame_err, 1'b1);
        chk("fe_no_valid", rx_valid, 1'b0);
        run_to(81); chk("fe_post", frame_err, 1'b0);
        settle();
        push_frame(8'h3C, 8, 1'b1);
        t = -1;
        run_to(80); chk("fe_next_valid", rx_valid, 1'b1);
        chk("fe_next_data", rx_data, 8'h3C);
        drain();
        settle();

        // Overrun with a stalled consumer
        push_frame(8'h11, 8, 1'b1);
        push_frame(8'h22, 8, 1'b1);
        t = -1;
        run_to(80);  chk("ov_first", rx_data, 8'h11);
        run_to(159); chk("ov_pre", overrun, 1'b0);
        run_to(160); chk("ov_pulse", overrun, 1'b1);
        chk("ov_keep_data", rx_data, 8'h11);
        chk("ov_keep_valid", rx_valid, 1'b1);
        run_to(161); chk("ov_post", overrun, 1'b0);
        drain();
        settle();

        // Simultaneous accept and load
        push_frame(8'h11, 8, 1'b1);
        push_frame(8'h22, 8, 1'b1);
        t = -1;
        run_to(80);  chk("sa_first", rx_data, 8'h11);
        run_to(159); rx_ready = 1'b1;
        run_to(160); rx_ready = 1'b0;
        chk("sa_data", rx_data, 8'h22);
        chk("sa_valid", rx_valid, 1'b1);
        chk("sa_no_ovr", overrun, 1'b0);
        drain();
        settle();

        // Divisor clamp
        baud = 20'd1;
        push_frame(8'h5A, 1, 1'b1);
        t = -1;
        run_to(land(1));     chk("cl_pre", rx_valid, 1'b0);
        run_to(land(1) + 1); chk("cl_valid", rx_valid, 1'b1);
        chk("cl_data", rx_data, 8'h5A);
        drain();
        settle();

        // Divisor latched at start detection
        baud = 20'd16;
        push_frame(8'h5A, 16, 1'b1);
        t = -1;
        run_to(40);  baud = 20'd32;
        run_to(155); chk("lat_pre", rx_valid, 1'b0);
        run_to(156); chk("lat_valid", rx_valid, 1'b1);
        chk("lat_data", rx_data, 8'h5A);
        baud = 20'd16;
        settle();

        // Reset mid-frame (0x5A still held in the buffer)
        push_frame(8'h96, 16, 1'b1);
        t = -1;
        run_to(88); chk("mr_busy", busy, 1'b1);
        rst = 1'b0;
        line_q.delete();
        #1;
        chk("mr_data", rx_data, 8'h00);
        chk("mr_valid", rx_valid, 1'b0);
        chk("mr_busy0", busy, 1'b0);
        chk("mr_ferr", frame_err, 1'b0);
        chk("mr_ovr", overrun, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        seen_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen_a |= rx_valid | frame_err | overrun | busy;
        end
        chk("mr_quiet", seen_a, 1'b0);
        push_frame(8'hC3, 16, 1'b1);
        t = -1;
        run_to(156); chk("mr_next_valid", rx_valid, 1'b1);
        chk("mr_next_data", rx_data, 8'hC3);
        settle();

        // Enable dropped mid-frame (0xC3 still held)
        baud = 20'd8;
        push_frame(8'hE7, 8, 1'b1);
        t = -1;
        run_to(20); chk("en_busy", busy, 1'b1);
        en = 1'b0;
        run_to(21); chk("en_idle", busy, 1'b0);
        chk("en_keep_data", rx_data, 8'hC3);
        seen_a = 1'b0;
        for (int i = 0; i < 90; i++) begin
            tick();
            seen_a |= busy | frame_err | overrun;
        end
        chk("en_quiet", seen_a, 1'b0);
        chk("en_held", rx_valid, 1'b1);
        drain();
        en = 1'b1;
        settle();

        // Random frames against the timing model
        for (int n = 0; n < 8; n++) begin
            rd = 8'($urandom);
            rb = $urandom_range(1, 12);
            rs = ($urandom_range(0, 3) != 0);
            baud = 20'(rb);
            l = land(rb);
            push_frame(rd, rb, rs);
            t = -1;
            run_to(l);     chk("rnd_pre", rx_valid, 1'b0);
            run_to(l + 1);
            if (rs) begin
                chk("rnd_valid", rx_valid, 1'b1);
                chk("rnd_data", rx_data, rd);
                chk("rnd_no_ferr", frame_err, 1'b0);
                drain();
            end else begin
                chk("rnd_ferr", frame_err, 1'b1);
                chk("rnd_no_valid", rx_valid, 1'b0);
            end
            settle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART block. Synchronises the serial line, detects start bits, schedules mid-bit sampling from a programmable baud divisor, assembles 8N1 frames LSB-first, and hands completed bytes to the consumer through a one-entry valid/ready buffer. It sits between the `rx_in` pin and the downstream byte consumer, and replaces free-running enable-driven sampling with a start-bit-aligned sequence.

## Interface
- `BAUD_W`, default 20: divisor width.
- `BAUD_MIN`, default 4: smallest divisor honoured; smaller programmed values are clamped to this.
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `en`  in  1: receiver enable.
- `baud`  in  BAUD_W: clocks per bit.
- `rx_in`  in  1: asynchronous serial line; idle high.
- `rx_data`  out  8: held byte.
- `rx_valid`  out  1: `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1: consumer accepts on `rx_valid & rx_ready`.
- `busy`  out  1: FSM is not in IDLE.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled as 0.
- `overrun`  out  1: one-cycle pulse when a good byte is dropped.

## Operation
- **Synchroniser:** `rx_in` goes through 2 flops to form `rx_s`, reset value 1. `rx_p` is `rx_s` delayed by one cycle. A falling edge is `rx_p & ~rx_s`.
- **Divisor latch:** on start detection, latch `B = max(baud, BAUD_MIN)` and `H = B>>1`. Changing `baud` mid-frame has no effect on that frame.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** on a falling edge with `en=1`, go to START and clear `cnt`.
- **START:** when `cnt == H-1`, sample `rx_s`.
  - 0: go to DATA, clear `cnt` and `bit_idx`.
  - 1: false start; go to IDLE with no output.
- **DATA:** when `cnt == B-1`, shift `rx_s` into `shreg` LSB-first, increment `bit_idx`, clear `cnt`. After `bit_idx` 7 is sampled, go to STOP.
- **STOP:** when `cnt == B-1`, sample `rx_s` and go to IDLE.
  - 1: good byte.
  - 0: pulse `frame_err`; discard the byte.
- **Output buffer on a good byte:**
  - Buffer empty, or drained by `rx_ready` in the same cycle: load `rx_data`; `rx_valid` is 1 next cycle.
  - Otherwise: pulse `overrun`, drop the new byte, keep the old one.
  - Simultaneous accept and load: `rx_valid` stays 1 and `rx_data` takes the new byte. No overrun.
- **`en` deasserted:** the FSM returns to IDLE the next cycle from any state; the partial frame is discarded. The buffer is untouched and still drains via `rx_ready`.
- **Counter width:** `cnt` is BAUD_W bits and never wraps, because it clears at `B-1`.

## Timing
- **Reset values:**
  - `rx_data` = 0x00; `rx_valid`, `busy`, `frame_err`, `overrun` = 0.
  - FSM in IDLE; `rx_s` and `rx_p` = 1.
- **Sample schedule:** let cycle D be the cycle in which the edge is detected.
  - Start sample at D+H.
  - Data bit k (0..7) at D+H+(k+1)·B.
  - Stop bit at D+H+9·B.
- **Output timing:** `rx_valid` rises at D+H+9·B+1. `frame_err` and `overrun` pulse in that same cycle.
- **Pin to detection:** 3 cycles from the pin falling edge to D (2 sync flops + edge register).
- **`busy`:** 1 from D+1 through the stop-sample cycle.
- **Back-to-back frames:** the next falling edge is accepted in the first IDLE cycle after STOP.
- **Reset mid-frame:** immediate return to the reset values. No partial byte and no pulses are emitted.

## Structure
- **Package `uart_pkg`:**
  - FSM state enum `rx_state_t` (IDLE, START, DATA, STOP).
  - `UART_DATA_W = 8`.
  - `UART_BAUD_W = 20`.
  - `UART_BAUD_MIN = 4`.
- **Sub-module `uart_rx_sync`:** 2-flop synchroniser plus edge register; outputs `rx_s` and `fall`.
- **Top level:** FSM, counters, shift register and output buffer.

## Test plan
- **Single frame:** `baud=16`, send 0xA5 (pin falls at cycle 0). Expect:
  - D = 3 and `busy` = 1 from cycle 4 through cycle 155.
  - `rx_valid` = 1 at cycle 156 with `rx_data` = 0xA5.
  - `rx_ready` pulsed at cycle 160 → `rx_valid` = 0 at cycle 161.
- **Glitch rejection:** `baud=16`, 3-cycle low pulse on an idle line. Expect `busy` = 1 until D+8, then IDLE. No `rx_valid`, no `frame_err`.
- **Framing error:** `baud=8`, send 0x3C with the stop bit held at 0. Expect:
  - `frame_err` = 1 for exactly one cycle, at D+4+72+1.
  - `rx_valid` stays 0.
  - A following good 0x3C frame is received correctly.
- **Overrun and simultaneous accept:** `baud=8`, send 0x11 then 0x22 back-to-back.
  - With `rx_ready=0`: `rx_data` = 0x11 and `overrun` pulses once.
  - Repeat with `rx_ready=1` only in the cycle the second byte lands: `rx_data` = 0x22, `rx_valid` stays 1, no `overrun`.
- **Clamp and divisor latch:**
  - `baud=1`, send 0x5A: sampled with B=4, H=2; `rx_data` = 0x5A.
  - `baud=16`, change to 32 mid-frame: 0x5A is still received at the B=16 schedule.
- **Reset and enable mid-frame:**
  - Assert `rst` (low) during DATA bit 4: all outputs at reset values; the next frame 0xC3 is received intact.
  - Drop `en` during DATA: IDLE next cycle; a held byte still drains via `rx_ready`.
